// File: rtl/convolution_coprocessor_pkg.sv
// Shared defaults and sizing helpers for the convolution coprocessor blocks.
package convolution_coprocessor_pkg;

  localparam int unsigned DATA_WIDTH_DEF  = 8;
  localparam int unsigned KERNEL_TAPS_DEF = 9;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int unsigned clog2_plus1(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int i = 0; i < 32; i++) begin
      if ((n >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/convolution_coprocessor_tap_line_reg.sv
// Single-stage register with enable and synchronous clear; enable wins over clear.
module convolution_coprocessor_tap_line_reg
  import convolution_coprocessor_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_q <= '0;
    end else if (en) begin
      q_q <= d;
    end else if (clr) begin
      q_q <= '0;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/convolution_coprocessor_tap_line.sv
// Delay line exposing the last DEPTH samples in parallel, with fill count,
// window-valid flag and a cascade port for chaining into a 2-D line buffer.
module convolution_coprocessor_tap_line
  import convolution_coprocessor_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = KERNEL_TAPS_DEF,
  parameter int unsigned CNT_WIDTH  = clog2_plus1(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        clrh,
  input  logic                        shift_i,
  input  logic [DATA_WIDTH-1:0]       data_i,
  output logic [DEPTH*DATA_WIDTH-1:0] taps_o,
  output logic [CNT_WIDTH-1:0]        count_o,
  output logic                        window_valid_o,
  output logic [DATA_WIDTH-1:0]       cascade_o,
  output logic                        cascade_valid_o
);

  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] tap [DEPTH];
  logic                  shift_en;

  // Clear must beat shift, but the stage register is enable-first.
  assign shift_en = shift_i & ~clrh;

  for (genvar k = 0; k < DEPTH; k++) begin : g_tap
    logic [DATA_WIDTH-1:0] stage_d;
    if (k == 0) begin : g_head
      assign stage_d = data_i;
    end else begin : g_body
      assign stage_d = tap[k-1];
    end

    convolution_coprocessor_tap_line_reg #(
      .WIDTH (DATA_WIDTH)
    ) u_stage (
      .clk  (clk),
      .rstn (rstn),
      .en   (shift_en),
      .clr  (clrh),
      .d    (stage_d),
      .q    (tap[k])
    );

    assign taps_o[k*DATA_WIDTH +: DATA_WIDTH] = tap[k];
  end

  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  window_valid_q, window_valid_d;
  logic [DATA_WIDTH-1:0] cascade_q, cascade_d;
  logic                  cascade_valid_q, cascade_valid_d;

  always_comb begin
    count_d         = count_q;
    cascade_d       = cascade_q;
    cascade_valid_d = 1'b0;
    if (clrh) begin
      count_d   = '0;
      cascade_d = '0;
    end else if (shift_i) begin
      count_d         = (count_q == FULL) ? count_q : count_q + CNT_WIDTH'(1);
      cascade_d       = tap[DEPTH-1];
      cascade_valid_d = (count_q == FULL);
    end
    window_valid_d = (count_d == FULL);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q         <= '0;
      window_valid_q  <= 1'b0;
      cascade_q       <= '0;
      cascade_valid_q <= 1'b0;
    end else begin
      count_q         <= count_d;
      window_valid_q  <= window_valid_d;
      cascade_q       <= cascade_d;
      cascade_valid_q <= cascade_valid_d;
    end
  end

  assign count_o         = count_q;
  assign window_valid_o  = window_valid_q;
  assign cascade_o       = cascade_q;
  assign cascade_valid_o = cascade_valid_q;

endmodule

// File: tb/tb_convolution_coprocessor_tap_line.sv
// Self-checking bench for the tap line: directed vector table, async reset
// mid-fill, and a randomised run against a queue-based reference model.
module tb_convolution_coprocessor_tap_line;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic              clk;
  logic              rstn;
  logic              clrh;
  logic              shift_i;
  logic [DW-1:0]     data_i;
  logic [DEPTH*DW-1:0] taps_o;
  logic [CW-1:0]     count_o;
  logic              window_valid_o;
  logic [DW-1:0]     cascade_o;
  logic              cascade_valid_o;

  convolution_coprocessor_tap_line #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .clrh            (clrh),
    .shift_i         (shift_i),
    .data_i          (data_i),
    .taps_o          (taps_o),
    .count_o         (count_o),
    .window_valid_o  (window_valid_o),
    .cascade_o       (cascade_o),
    .cascade_valid_o (cascade_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          clr;
    logic          shift;
    logic [DW-1:0] data;
    logic [31:0]   taps;
    logic [CW-1:0] count;
    logic          wv;
    logic [DW-1:0] cas;
    logic          cv;
  } vec_t;

  vec_t vecs [9];
  vec_t exp_q [$];

  int unsigned n_vec;
  int unsigned n_bad;

  logic [DW-1:0] m_tap [DEPTH];
  logic [CW-1:0] m_count;
  logic [DW-1:0] m_cas;
  logic          m_cv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out();
    vec_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard: got empty queue expected one entry");
    end else begin
      e = exp_q.pop_front();
      chk("taps", taps_o, e.taps);
      chk("count", 32'(count_o), 32'(e.count));
      chk("window_valid", 32'(window_valid_o), 32'(e.wv));
      chk("cascade", 32'(cascade_o), 32'(e.cas));
      chk("cascade_valid", 32'(cascade_valid_o), 32'(e.cv));
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    clrh    = v.clr;
    shift_i = v.shift;
    data_i  = v.data;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic model_step(input logic c, input logic s, input logic [DW-1:0] d,
                            output vec_t v);
    if (c) begin
      for (int k = 0; k < DEPTH; k++) m_tap[k] = '0;
      m_count = '0;
      m_cas   = '0;
      m_cv    = 1'b0;
    end else if (s) begin
      m_cv  = (m_count == CW'(DEPTH));
      m_cas = m_tap[DEPTH-1];
      for (int k = DEPTH - 1; k > 0; k--) m_tap[k] = m_tap[k-1];
      m_tap[0] = d;
      if (m_count != CW'(DEPTH)) m_count = m_count + 1'b1;
    end else begin
      m_cv = 1'b0;
    end
    v.clr   = c;
    v.shift = s;
    v.data  = d;
    v.taps  = {m_tap[3], m_tap[2], m_tap[1], m_tap[0]};
    v.count = m_count;
    v.wv    = (m_count == CW'(DEPTH));
    v.cas   = m_cas;
    v.cv    = m_cv;
  endtask

  initial begin
    vec_t rv;
    logic rc, rs;
    logic [DW-1:0] rd;

    n_vec = 0;
    n_bad = 0;
    //           clr   shift data   taps          cnt  wv    cas    cv
    vecs[0] = '{1'b0, 1'b1, 8'h11, 32'h00000011, 3'd1, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'h22, 32'h00001122, 3'd2, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'h33, 32'h00112233, 3'd3, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 8'h44, 32'h11223344, 3'd4, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 8'h55, 32'h22334455, 3'd4, 1'b1, 8'h11, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 8'h66, 32'h22334455, 3'd4, 1'b1, 8'h11, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 8'h77, 32'h22334455, 3'd4, 1'b1, 8'h11, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 8'h88, 32'h22334455, 3'd4, 1'b1, 8'h11, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 8'hAA, 32'h00000000, 3'd0, 1'b0, 8'h00, 1'b0};

    rstn    = 1'b0;
    clrh    = 1'b0;
    shift_i = 1'b0;
    data_i  = '0;
    #12;
    chk("reset_taps", taps_o, 32'h0);
    chk("reset_count", 32'(count_o), 32'h0);
    chk("reset_wv", 32'(window_valid_o), 32'h0);
    chk("reset_cascade", 32'(cascade_o), 32'h0);
    chk("reset_cv", 32'(cascade_valid_o), 32'h0);
    rstn = 1'b1;

    for (int i = 0; i < 9; i++) apply(vecs[i]);

    // Async reset mid-fill, asserted and released between clock edges.
    apply(vecs[0]);
    apply(vecs[1]);
    #2;
    shift_i = 1'b0;
    rstn    = 1'b0;
    #1;
    chk("async_taps", taps_o, 32'h0);
    chk("async_count", 32'(count_o), 32'h0);
    chk("async_wv", 32'(window_valid_o), 32'h0);
    chk("async_cascade", 32'(cascade_o), 32'h0);
    chk("async_cv", 32'(cascade_valid_o), 32'h0);
    #2;
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) apply(vecs[i]);
    apply(vecs[8]);

    for (int k = 0; k < DEPTH; k++) m_tap[k] = '0;
    m_count = '0;
    m_cas   = '0;
    m_cv    = 1'b0;
    for (int i = 0; i < 100; i++) begin
      rc = ($urandom_range(0, 24) == 0);
      rs = ($urandom_range(0, 3) != 0);
      rd = DW'($urandom_range(0, 255));
      model_step(rc, rs, rd, rv);
      apply(rv);
    end

    @(negedge clk);
    shift_i = 1'b0;
    clrh    = 1'b0;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/convolution_coprocessor_tap_line.md
Name: convolution_coprocessor_tap_line

Overview:
- Parametrised shift-register delay line that holds the last DEPTH samples of a convolution operand stream and exposes every tap in parallel to the MAC array.
- Adds a fill counter, window-valid flag and a cascade output (the sample shifted off the end) so several tap lines can be chained into a 2-D line buffer.
- Sits between the operand fetch stage and the multiply-accumulate datapath of the convolution coprocessor.

Parameters:
- DATA_WIDTH, 8, width of one sample in bits.
- DEPTH, 9, number of taps (9 = one 3x3 kernel window); legal range 2..64.
- CNT_WIDTH, $clog2(DEPTH+1), width of the fill counter; derived, not to be overridden.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous, active-low reset.
- clrh  in  1  synchronous clear, active high.
- shift_i  in  1  shift enable; one sample is accepted per cycle while high.
- data_i  in  DATA_WIDTH  sample entering tap 0.
- taps_o  out  DEPTH*DATA_WIDTH  all taps, flat; tap k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]; tap 0 is the newest sample.
- count_o  out  CNT_WIDTH  number of valid samples held, saturating at DEPTH.
- window_valid_o  out  1  high when count_o == DEPTH.
- cascade_o  out  DATA_WIDTH  sample shifted out of tap DEPTH-1.
- cascade_valid_o  out  1  one-cycle strobe qualifying cascade_o.

Behaviour:
- Reset (rstn low, asynchronous): all taps 0, count_o 0, window_valid_o 0, cascade_o 0, cascade_valid_o 0. No clock is needed for reset to take effect.
- Priority at each rising edge is clrh > shift_i > hold.
- clrh=1:
  - All taps, count_o, cascade_o and cascade_valid_o go to 0.
  - A coincident shift_i is discarded; data_i is not captured.
- shift_i=1, clrh=0:
  - tap[0] <= data_i; tap[k] <= tap[k-1] for k = 1..DEPTH-1.
  - cascade_o <= old tap[DEPTH-1].
  - cascade_valid_o <= 1 only if count_o == DEPTH before the edge; otherwise 0.
  - count_o <= min(count_o+1, DEPTH).
- Neither asserted:
  - Taps, count_o and cascade_o hold their values.
  - cascade_valid_o <= 0, so it is a single-cycle strobe per shift.
- Latency:
  - data_i appears on tap 0 one cycle after the accepting edge.
  - The sample reaches cascade_o DEPTH accepted shifts after capture.
- window_valid_o:
  - Registered; equals (next count_o == DEPTH).
  - Rises in the cycle after the DEPTH-th accepted shift and stays high until clrh or reset.
- Fill/empty boundaries:
  - Before DEPTH shifts, unfilled taps read 0 (reset/clear value).
  - count_o never exceeds DEPTH and never wraps.
  - There is no empty underflow, because count_o only decrements via clear.
- Back-pressure: none. shift_i is always accepted, and the consumer must sample taps_o while window_valid_o is high.
- Reset mid-stream: state returns to empty immediately and the stream restarts from count 0.
- All outputs are driven directly from flops; there is no combinational path from any input to any output.

Decomposition:
- Shared package convolution_coprocessor_pkg:
  - DATA_WIDTH_DEF = 8.
  - KERNEL_TAPS_DEF = 9.
  - A function clog2_plus1(n) for counter sizing.
- One natural sub-module is the existing single-stage enable/clear register, instantiated DEPTH times in a generate loop for the tap chain.
  - Its enable/clear priority is enable-first, so the tap line drives its enable as shift_i & ~clrh to enforce clear priority.
- The fill counter, window flag and cascade stage are local logic in this module.

Test Plan (DEPTH=4, DATA_WIDTH=8):
- Reset then 4 shifts of 0x11,0x22,0x33,0x44.
  - count_o steps 1,2,3,4.
  - window_valid_o rises after the 4th shift.
  - taps_o = {0x11,0x22,0x33,0x44} (tap3..tap0).
  - cascade_valid_o never asserted.
- Continue with a 5th shift of 0x55:
  - cascade_o = 0x11 with cascade_valid_o high for exactly 1 cycle.
  - tap0 = 0x55.
  - count_o stays 4.
- shift_i low for 3 cycles after fill: taps_o, count_o and cascade_o are unchanged, and cascade_valid_o is 0.
- clrh and shift_i high in the same cycle with data_i=0xAA:
  - All taps 0, count_o 0, window_valid_o 0.
  - 0xAA is not captured.
- Assert rstn low asynchronously between clock edges mid-fill (count_o=2): all outputs are 0 before the next edge, and refill after release behaves as in the first scenario.
- 100 random shift_i/data_i cycles against a queue model: taps_o, count_o and cascade_o/cascade_valid_o match the model every cycle.
